// File: rtl/snake_pkg.sv
// Shared types for the snake game sequencer: directions, FSM states and grid width.
package snake_pkg;

    localparam int GRID_W = 3;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STEP,
        CHECK,
        OVER
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            UP:      return DOWN;
            default: return UP;
        endcase
    endfunction

endpackage

// File: rtl/snake_tick_divider.sv
// Game-step divider: counts enabled cycles and flags the last cycle of each tick.
module snake_tick_divider #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tc = en && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + CNT_W'(1);
    end

endmodule

// File: rtl/snake_step_controller.sv
// Snake game sequencer: latches direction, emits one move pulse per tick,
// reloads the head on start and stops on collision.
module snake_step_controller
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25,
    parameter int START_X  = 3,
    parameter int START_Y  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              btn_u,
    input  logic              btn_d,
    input  logic              start,
    input  logic              edge_collision,
    input  logic              body_collision,
    output logic              l,
    output logic              r,
    output logic              u,
    output logic              d,
    output logic              load,
    output logic [GRID_W-1:0] load_x,
    output logic [GRID_W-1:0] load_y,
    output logic              running,
    output logic              game_over,
    output logic [7:0]        step_count
);

    state_t state, state_nx;
    dir_t   dir, next_dir, dir_base, btn_dir;
    logic   btn_ok, tick_tc, hit;

    assign hit = edge_collision | body_collision;

    snake_tick_divider #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (state == RUN),
        .clr   (state != RUN),
        .tc    (tick_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (tick_tc) state_nx = STEP;
            STEP:    state_nx = CHECK;
            CHECK:   state_nx = hit ? OVER : RUN;
            OVER:    if (start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Reversals are judged against the direction that will be committed after
    // this edge, so a press on the commit cycle cannot sneak in a 180-degree turn.
    always_comb begin
        dir_base = tick_tc ? next_dir : dir;
        btn_ok   = 1'b1;
        btn_dir  = next_dir;
        if (btn_l && opposite(dir_base) != LEFT)
            btn_dir = LEFT;
        else if (btn_r && opposite(dir_base) != RIGHT)
            btn_dir = RIGHT;
        else if (btn_u && opposite(dir_base) != UP)
            btn_dir = UP;
        else if (btn_d && opposite(dir_base) != DOWN)
            btn_dir = DOWN;
        else
            btn_ok = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir      <= RIGHT;
            next_dir <= RIGHT;
        end else if (state == LOAD) begin
            dir      <= RIGHT;
            next_dir <= RIGHT;
        end else begin
            if (tick_tc)
                dir <= next_dir;
            if (btn_ok && state != OVER)
                next_dir <= btn_dir;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            step_count <= 8'd0;
        else if (state == LOAD)
            step_count <= 8'd0;
        else if (state == CHECK && !hit && step_count != 8'hFF)
            step_count <= step_count + 8'd1;
    end

    assign l         = (state == STEP) && (dir == LEFT);
    assign r         = (state == STEP) && (dir == RIGHT);
    assign u         = (state == STEP) && (dir == UP);
    assign d         = (state == STEP) && (dir == DOWN);
    assign load      = (state == LOAD);
    assign running   = (state == RUN) || (state == STEP) || (state == CHECK);
    assign game_over = (state == OVER);
    assign load_x    = GRID_W'(START_X);
    assign load_y    = GRID_W'(START_Y);

endmodule

// File: tb/tb_snake_step_controller.sv
// Directed bench for snake_step_controller with a four-cycle game tick.
module tb_snake_step_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       edge_collision = 1'b0;
    logic       body_collision = 1'b0;
    logic [3:0] btn = 4'b0000;   // {l, r, u, d}
    logic       l, r, u, d, load, running, game_over;
    logic [2:0] load_x, load_y;
    logic [7:0] step_count;
    logic [3:0] mv;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] MV_L = 4'b1000;
    localparam logic [3:0] MV_R = 4'b0100;
    localparam logic [3:0] MV_U = 4'b0010;

    assign mv = {l, r, u, d};

    snake_step_controller #(
        .TICK_DIV (4),
        .CNT_W    (3),
        .START_X  (3),
        .START_Y  (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_l          (btn[3]),
        .btn_r          (btn[2]),
        .btn_u          (btn[1]),
        .btn_d          (btn[0]),
        .start          (start),
        .edge_collision (edge_collision),
        .body_collision (body_collision),
        .l              (l),
        .r              (r),
        .u              (u),
        .d              (d),
        .load           (load),
        .load_x         (load_x),
        .load_y         (load_y),
        .running        (running),
        .game_over      (game_over),
        .step_count     (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] btn;
        logic       ecol;
        logic [3:0] mv;
        logic       load;
        logic       run;
        logic       over;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a move pulse shows up; n is the number of edges taken.
    task automatic wait_move(output logic [3:0] got, output int n);
        got = 4'b0000;
        n   = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (mv != 4'b0000) begin
                got = mv;
                break;
            end
        end
        if (got == 4'b0000)
            chk("move_timeout", 0, 1);
    endtask

    initial begin
        logic [3:0] got;
        int         n;
        int         bad;

        //            start btn     ecol  mv      load  run   over  cnt
        vt[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0};
        vt[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};
        vt[8]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};
        vt[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};
        vt[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};
        vt[11] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd1};
        vt[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};
        vt[13] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd2};

        tick();
        tick();
        chk("rst_mv", int'(mv), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_cnt", int'(step_count), 0);
        chk("load_x", int'(load_x), 3);
        chk("load_y", int'(load_y), 3);
        reset = 1'b0;
        tick();
        chk("idle_running", int'(running), 0);

        for (int i = 0; i < 14; i++) begin
            start          = vt[i].start;
            btn            = vt[i].btn;
            edge_collision = vt[i].ecol;
            tick();
            chk($sformatf("vec%0d_mv", i), int'(mv), int'(vt[i].mv));
            chk($sformatf("vec%0d_load", i), int'(load), int'(vt[i].load));
            chk($sformatf("vec%0d_running", i), int'(running), int'(vt[i].run));
            chk($sformatf("vec%0d_over", i), int'(game_over), int'(vt[i].over));
            chk($sformatf("vec%0d_cnt", i), int'(step_count), int'(vt[i].cnt));
        end
        btn = 4'b0000;

        // third step goes up; collision and start arrive together in CHECK
        wait_move(got, n);
        chk("step3_dir", int'(got), int'(MV_U));
        chk("step3_gap", n, 4);
        edge_collision = 1'b1;
        start          = 1'b1;
        tick();
        chk("check_mv", int'(mv), 0);
        chk("check_running", int'(running), 1);
        tick();
        edge_collision = 1'b0;
        start          = 1'b0;
        chk("over_flag", int'(game_over), 1);
        chk("over_running", int'(running), 0);
        chk("over_cnt", int'(step_count), 2);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mv != 4'b0000 || !game_over || load)
                bad++;
        end
        chk("over_quiet_cycles_bad", bad, 0);

        // restart from OVER while last direction was UP
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_load", int'(load), 1);
        chk("restart_over", int'(game_over), 0);
        wait_move(got, n);
        chk("restart_dir", int'(got), int'(MV_R));
        chk("restart_latency", n, 5);
        chk("restart_cnt", int'(step_count), 0);

        // l+u held while moving right: l is a reversal, u wins
        btn = 4'b1010;
        tick();
        btn = 4'b0000;
        wait_move(got, n);
        chk("fallthru_dir", int'(got), int'(MV_U));
        chk("fallthru_gap", n + 1, 6);

        btn = 4'b0100;
        tick();
        btn = 4'b0000;
        wait_move(got, n);
        chk("turn_right_dir", int'(got), int'(MV_R));

        // u then l inside one tick: l rejected against committed RIGHT
        btn = 4'b0010;
        tick();
        btn = 4'b1000;
        tick();
        btn = 4'b0000;
        wait_move(got, n);
        chk("u_then_l_dir", int'(got), int'(MV_U));

        btn = 4'b1000;
        tick();
        btn = 4'b0000;
        wait_move(got, n);
        chk("left_after_up_dir", int'(got), int'(MV_L));
        chk("mid_cnt", int'(step_count), 4);

        // asynchronous reset while the l pulse is high
        reset = 1'b1;
        #1;
        chk("async_rst_mv", int'(mv), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_cnt", int'(step_count), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", int'(running), 0);

        // long safe run: saturation at 255
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wait_move(got, n);
            chk($sformatf("sat_dir%0d", i), int'(got), int'(MV_R));
            chk($sformatf("sat_gap%0d", i), n, (i == 0) ? 5 : 6);
            if (i == 254 || i == 255 || i == 299)
                chk($sformatf("sat_cnt_at%0d", i), int'(step_count), (i > 255) ? 255 : i);
        end
        tick();
        tick();
        chk("sat_final", int'(step_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
